// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand sequencer.
// The optional button debounce is selected with the BTN_DEBOUNCE_EN macro.
package alu_pkg;

    localparam int DEF_DATA_W    = 4;
    localparam int DEF_CODE_W    = 3;
    localparam int DEF_DB_CYCLES = 16;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        RUN     = 2'd3
    } state_e;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_NOT = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_LT  = 3'd6;
    localparam logic [2:0] OP_EQ  = 3'd7;

endpackage

// File: rtl/btn_cond.sv
// Button conditioner: 2-flop synchronizer, optional debounce (BTN_DEBOUNCE_EN),
// and a rising-edge detector that emits a single-cycle pulse per press.
module btn_cond #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic level;
    logic prev;
    logic seen;
    logic armed;

    if (DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_db_range
        $error("btn_cond: DB_CYCLES must be in 1..255");
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    logic [7:0] cnt;

    // Level follows the synchronized input only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b0;
            cnt   <= 8'd0;
        end else if (sync2 == level) begin
            cnt <= 8'd0;
        end else if (cnt == 8'(DB_CYCLES - 1)) begin
            level <= sync2;
            cnt   <= 8'd0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end
`else
    assign level = sync2;
`endif

    // Pulses are only armed once the whole chain has been seen idle after reset,
    // so a button held through reset release cannot fire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev  <= 1'b0;
            seen  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev <= level;
            seen <= 1'b1;
            if (seen && !sync1 && !sync2 && !level)
                armed <= 1'b1;
        end
    end

    assign pulse = level & ~prev & armed;

endmodule

// File: rtl/alu_operand_seq.sv
// Steps operand A, operand B and opcode from switches into ALU-facing registers.
// Optional button debounce is compiled in with BTN_DEBOUNCE_EN.
module alu_operand_seq
    import alu_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CODE_W    = DEF_CODE_W,
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sw,
    input  logic              btn_step,
    input  logic              btn_clr,
    output logic [DATA_W-1:0] opa,
    output logic [DATA_W-1:0] opb,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic [1:0]        stage
);

    state_e state;
    logic   step_p;
    logic   clr_p;

    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_step (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_step),
        .pulse (step_p)
    );

    btn_cond #(.DB_CYCLES(DB_CYCLES)) u_clr (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_clr),
        .pulse (clr_p)
    );

    // Clear outranks step when both pulse in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD_A;
            opa   <= '0;
            opb   <= '0;
            code  <= '0;
        end else if (clr_p) begin
            state <= LOAD_A;
            opa   <= '0;
            opb   <= '0;
            code  <= '0;
        end else if (step_p) begin
            unique case (state)
                LOAD_A: begin
                    opa   <= sw;
                    state <= LOAD_B;
                end
                LOAD_B: begin
                    opb   <= sw;
                    state <= LOAD_OP;
                end
                LOAD_OP: begin
                    code  <= sw[CODE_W-1:0];
                    state <= RUN;
                end
                RUN: begin
                    state <= LOAD_A;
                end
                default: begin
                    state <= LOAD_A;
                end
            endcase
        end
    end

    assign valid = (state == RUN);
    assign stage = state;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Self-checking bench for alu_operand_seq: vector table, corner-case sequences and
// randomized presses against a press-level reference model.
module tb_alu_operand_seq;

    localparam int DW = 4;
    localparam int CW = 3;
    localparam int DB = 16;
`ifdef BTN_DEBOUNCE_EN
    localparam int HOLD    = DB + 4;
    localparam int EXP_LAT = 3 + DB;
`else
    localparam int HOLD    = 3;
    localparam int EXP_LAT = 3;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] sw;
    logic          btn_step;
    logic          btn_clr;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic [CW-1:0] code;
    logic          valid;
    logic [1:0]    stage;

    alu_operand_seq #(.DATA_W(DW), .CODE_W(CW), .DB_CYCLES(DB)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .btn_step (btn_step),
        .btn_clr  (btn_clr),
        .opa      (opa),
        .opb      (opb),
        .code     (code),
        .valid    (valid),
        .stage    (stage)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: stage index plus the three latched registers, indexed by stage.
    int            m_stage;
    logic [DW-1:0] m_reg [3];

    typedef struct {
        bit         s;
        bit         c;
        logic [3:0] v;
        int         e_stage;
        int         e_opa;
        int         e_opb;
        int         e_code;
        int         e_valid;
    } vec_t;

    vec_t tbl [9];

    function automatic logic [DW-1:0] alu(logic [DW-1:0] a, logic [DW-1:0] b, logic [CW-1:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return ~a;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            3'd6:    return (a < b) ? 4'd1 : 4'd0;
            default: return (a == b) ? 4'd1 : 4'd0;
        endcase
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stage = 0;
        for (int i = 0; i < 3; i++) m_reg[i] = '0;
    endtask

    task automatic model_step(input logic [DW-1:0] v);
        if (m_stage < 3) m_reg[m_stage] = v;
        m_stage = (m_stage + 1) % 4;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".stage"}, int'(stage), m_stage);
        check({tag, ".opa"},   int'(opa),   int'(m_reg[0]));
        check({tag, ".opb"},   int'(opb),   int'(m_reg[1]));
        check({tag, ".code"},  int'(code),  int'(m_reg[2][CW-1:0]));
        check({tag, ".valid"}, int'(valid), (m_stage == 3) ? 1 : 0);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit s, input bit c, input logic [DW-1:0] v);
        @(negedge clk);
        sw       = v;
        btn_step = s;
        btn_clr  = c;
        cyc(HOLD);
        btn_step = 1'b0;
        btn_clr  = 1'b0;
        cyc(HOLD + 2);
        if (c) model_reset();
        else if (s) model_step(v);
    endtask

    initial begin
        int            lat;
        logic [DW-1:0] rv;
        int            r;

        tbl[0] = '{1'b1, 1'b0, 4'h3, 1,  3, 0, 0, 0};
        tbl[1] = '{1'b1, 1'b0, 4'h5, 2,  3, 5, 0, 0};
        tbl[2] = '{1'b1, 1'b0, 4'h1, 3,  3, 5, 1, 1};
        tbl[3] = '{1'b1, 1'b0, 4'h9, 0,  3, 5, 1, 0};
        tbl[4] = '{1'b1, 1'b0, 4'hA, 1, 10, 5, 1, 0};
        tbl[5] = '{1'b0, 1'b1, 4'h7, 0,  0, 0, 0, 0};
        tbl[6] = '{1'b1, 1'b0, 4'hF, 1, 15, 0, 0, 0};
        tbl[7] = '{1'b1, 1'b0, 4'h2, 2, 15, 2, 0, 0};
        tbl[8] = '{1'b1, 1'b0, 4'hE, 3, 15, 2, 6, 1};

        rst      = 1'b1;
        sw       = '0;
        btn_step = 1'b0;
        btn_clr  = 1'b0;
        model_reset();
        cyc(3);
        check_model("reset");
        rst = 1'b0;
        cyc(4);

        // Vector table: basic sequence, wrap, clear, upper opcode bits ignored.
        for (int i = 0; i < 9; i++) begin
            press(tbl[i].s, tbl[i].c, tbl[i].v);
            check($sformatf("vec%0d.stage", i), int'(stage), tbl[i].e_stage);
            check($sformatf("vec%0d.opa", i),   int'(opa),   tbl[i].e_opa);
            check($sformatf("vec%0d.opb", i),   int'(opb),   tbl[i].e_opb);
            check($sformatf("vec%0d.code", i),  int'(code),  tbl[i].e_code);
            check($sformatf("vec%0d.valid", i), int'(valid), tbl[i].e_valid);
            if (i == 2) check("alu_res", int'(alu(opa, opb, code)), 14);
        end

        // Simultaneous step and clear in LOAD_OP.
        press(1'b0, 1'b1, 4'h0);
        press(1'b1, 1'b0, 4'h3);
        press(1'b1, 1'b0, 4'h7);
        check_model("pre_simul");
        press(1'b1, 1'b1, 4'h5);
        check_model("simul");

        // Press-to-update latency.
        @(negedge clk);
        sw       = 4'h6;
        btn_step = 1'b1;
        lat      = 0;
        for (int k = 1; k <= EXP_LAT + 10; k++) begin
            @(posedge clk);
            #1;
            if (lat == 0 && stage != 2'd0) lat = k;
        end
        btn_step = 1'b0;
        cyc(HOLD + 2);
        model_step(4'h6);
        check("latency", lat, EXP_LAT);
        check_model("latency");

`ifdef BTN_DEBOUNCE_EN
        // Bouncing press must yield a single advance 19 cycles after the final rise.
        @(negedge clk);
        sw = 4'hC;
        repeat (3) begin
            btn_step = 1'b1;
            cyc(5);
            btn_step = 1'b0;
            cyc(3);
        end
        btn_step = 1'b1;
        lat      = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (lat == 0 && int'(stage) != m_stage) lat = k;
        end
        btn_step = 1'b0;
        cyc(DB + 6);
        model_step(4'hC);
        check("bounce_latency", lat, 19);
        check_model("bounce");
`endif

        // Long hold produces exactly one advance.
        press(1'b0, 1'b1, 4'h0);
        @(negedge clk);
        sw       = 4'h4;
        btn_step = 1'b1;
        cyc(100);
        btn_step = 1'b0;
        cyc(HOLD + 2);
        model_step(4'h4);
        check_model("hold");

        // Asynchronous reset in RUN, with step held through release.
        press(1'b0, 1'b1, 4'h0);
        press(1'b1, 1'b0, 4'h2);
        press(1'b1, 1'b0, 4'h3);
        press(1'b1, 1'b0, 4'h4);
        check_model("pre_rst");
        @(posedge clk);
        #2;
        btn_step = 1'b1;
        rst      = 1'b1;
        #1;
        model_reset();
        check_model("async_rst");
        cyc(3);
        rst = 1'b0;
        cyc(HOLD + 10);
        check_model("held_rst");
        btn_step = 1'b0;
        cyc(HOLD + 2);
        press(1'b1, 1'b0, 4'h8);
        check_model("after_rst");

        // Randomized presses against the model.
        for (int i = 0; i < 40; i++) begin
            r  = int'($urandom_range(0, 9));
            rv = 4'($urandom);
            if (r < 7)      press(1'b1, 1'b0, rv);
            else if (r < 9) press(1'b0, 1'b1, rv);
            else            press(1'b1, 1'b1, rv);
            check_model($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_seq.md
ALU_OPERAND_SEQ -- requirements
Module: alu_operand_seq

Interface
Parameters:
REQ-001 SHALL have DATA_W, default 4, the operand width driven to the ALU.
REQ-002 SHALL have CODE_W, default 3, the opcode width driven to the ALU.
REQ-003 SHALL have DB_CYCLES, default 16, the number of cycles a button must be stable when debounce is compiled in (legal range 1..255).
Ports:
REQ-004 SHALL have clk  input  1  the single system clock; all state updates on its rising edge.
REQ-005 SHALL have rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have sw  input  DATA_W  raw switch value; asynchronous to clk.
REQ-007 SHALL have btn_step  input  1  raw step button, asynchronous, active-high.
REQ-008 SHALL have btn_clr  input  1  raw clear button, asynchronous, active-high.
REQ-009 SHALL have opa  output  DATA_W  latched operand A to the ALU.
REQ-010 SHALL have opb  output  DATA_W  latched operand B to the ALU.
REQ-011 SHALL have code  output  CODE_W  latched opcode to the ALU.
REQ-012 SHALL have valid  output  1  high while opa, opb and code form a complete, stable ALU request.
REQ-013 SHALL have stage  output  2  current state encoding, for LEDs.

Function
REQ-014 SHALL pass each button through a 2-flop synchronizer, then a conditioner, then a rising-edge detector producing a 1-cycle pulse (step_p, clr_p).
REQ-015 SHALL implement 4 states: LOAD_A=0, LOAD_B=1, LOAD_OP=2, RUN=3; stage equals this encoding.
REQ-016 SHALL, on step_p in LOAD_A, latch sw into opa and go to LOAD_B.
REQ-017 SHALL, on step_p in LOAD_B, latch sw into opb and go to LOAD_OP.
REQ-018 SHALL, on step_p in LOAD_OP, latch sw[CODE_W-1:0] into code, ignore the upper sw bits, go to RUN, and set valid.
REQ-019 SHALL, on step_p in RUN, clear valid and go to LOAD_A while keeping opa, opb and code unchanged.
REQ-020 SHALL hold valid high throughout RUN and low in every other state.
REQ-021 SHALL hold opa, opb and code constant except on the latching events above and on clear.
REQ-022 SHALL, on clr_p in any state, zero opa, opb and code, clear valid, and go to LOAD_A.
REQ-023 SHALL give clr_p priority over step_p when both pulse in the same cycle.
REQ-024 SHALL advance exactly one state per press; a held button produces no further pulses.
REQ-025 SHALL, without debounce, show a register or state update at the 3rd rising edge after a button's synchronized sample first sees the high level (2 sync + 1 edge-detect).

Reset
REQ-026 SHALL, while rst is high, asynchronously force state=LOAD_A, opa=0, opb=0, code=0, valid=0, synchronizer and edge-detect flops to 0, and debounce counters to 0.
REQ-027 SHALL generate no pulse at reset release when a button is already held; a release-and-press is required.
REQ-028 SHALL, if rst asserts mid-debounce or mid-sequence, abort all progress; no partial latch survives.

Configuration
REQ-029 SHALL use macro BTN_DEBOUNCE_EN.
REQ-030 SHALL, when BTN_DEBOUNCE_EN is defined, update each conditioned level only after the synchronized input differs from it for DB_CYCLES consecutive cycles; any bounce restarts the count; update latency = 3 + DB_CYCLES cycles.
REQ-031 SHALL, when BTN_DEBOUNCE_EN is undefined, make the conditioned level the synchronized level, with no counter logic instantiated.

Structure
REQ-032 SHALL place the state enum, the ALU opcode constants (ADD=0, SUB=1, NOT=2, AND=3, OR=4, XOR=5, LT=6, EQ=7) and the default widths in shared package alu_pkg.
REQ-033 SHALL use one sub-module, btn_cond (synchronizer + optional debounce + edge detect, pulse output), instantiated twice.

Verification
REQ-034 SHALL cover the sequence: with debounce off, press step with sw=4'h3, then 4'h5, then 4'h1 -> opa=3, opb=5, code=1, valid=1, stage=3, and a downstream ALU gives res=4'hE.
REQ-035 SHALL cover wrap: in RUN, press step -> stage=0, valid=0, opa/opb/code unchanged.
REQ-036 SHALL cover simultaneous press: in LOAD_OP with opa=3, pulse step and clr in the same cycle -> stage=0, opa=0, code unchanged at 0, valid=0.
REQ-037 SHALL cover debounce: with debounce on, DB_CYCLES=16, btn_step bounces 5 high/3 low cycles, then holds high 20 cycles -> exactly one advance, 19 cycles after the final rising edge.
REQ-038 SHALL cover hold: btn_step held 100 cycles in LOAD_A -> exactly one advance to LOAD_B.
REQ-039 SHALL cover reset: assert rst asynchronously in RUN between clock edges -> outputs zero immediately; btn_step held through the rst release produces no advance.
